data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, address width of both requester ports and of the memory port.
REQ-002 Parameter: DATA_W, default 64, data width of both requester ports and of the memory port.
REQ-003 Parameter: BURST_MAX, default 4, maximum consecutive locked debug grants while the core is waiting.
REQ-004 clk  input  1  the single clock for the block; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 core_req / core_we  input  1 / 1  core load/store request; core_we high means store.
REQ-007 core_addr / core_wdata  input  ADDR_W / DATA_W  core address and store data.
REQ-008 core_gnt / core_rvalid  output  1 / 1  core granted this cycle / core load data valid.
REQ-009 core_rdata  output  DATA_W  core load data.
REQ-010 core_stall  output  1  equals core_req AND NOT core_gnt, used to freeze the PC.
REQ-011 dbg_req / dbg_we / dbg_lock  input  1 / 1 / 1  debug/loader request, store flag, and burst lock.
REQ-012 dbg_addr / dbg_wdata  input  ADDR_W / DATA_W  debug address and store data.
REQ-013 dbg_gnt / dbg_rvalid / dbg_rdata  output  1 / 1 / DATA_W  debug grant, load-valid and load data.
REQ-014 mem_read / mem_write  output  1 / 1  strobes to the data memory.
REQ-015 mem_addr / mem_wdata  output  ADDR_W / DATA_W  memory address and store data.
REQ-016 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.

Function
REQ-017 At most one of core_gnt and dbg_gnt SHALL be high in any cycle.
REQ-018 Grants SHALL be combinational from the current requests and registered state, so a grant occurs in the same cycle as the request.
REQ-019 The FSM SHALL have three states: IDLE (no grant last cycle), CORE (core granted last cycle), and DBG (debug granted last cycle); the next state is the owner granted this cycle, or IDLE if none.
REQ-020 With a single requester, that requester SHALL be granted.
REQ-021 With both requesting, the port not granted most recently (last_owner register) SHALL win, i.e. round-robin.
REQ-022 Exception: in DBG with dbg_lock high and burst_cnt < BURST_MAX, debug SHALL win over a simultaneous core request.
REQ-023 burst_cnt SHALL increment on each debug grant made while core_req is high, SHALL saturate at BURST_MAX, and SHALL clear on any core grant or on any cycle in which debug is not granted.
REQ-024 The memory outputs SHALL be driven from the granted port: mem_addr and mem_wdata, mem_read = gnt AND NOT we, mem_write = gnt AND we.
REQ-025 With no grant, mem_read and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL hold the core's values.
REQ-026 On a granted read, mem_rdata SHALL be registered at that edge, and the granted port's rvalid SHALL pulse high for exactly the next cycle, with rdata carrying the value (1-cycle latency).
REQ-027 core_rdata and dbg_rdata SHALL hold their last loaded value when rvalid is low.
REQ-028 Writes SHALL produce no rvalid.
REQ-029 Back-to-back reads on the same or alternating ports SHALL each yield one rvalid pulse, in order.
REQ-030 If dbg_lock drops mid-burst, round-robin SHALL resume in the same cycle.
REQ-031 A request withdrawn before grant SHALL be dropped, with no state change.

Reset
REQ-032 While reset is high, the following SHALL hold:
- state = IDLE;
- last_owner = DBG, so the core wins the first tie;
- burst_cnt = 0;
- all gnt, rvalid, mem_read, mem_write outputs = 0;
- rdata registers = 0.
REQ-033 Reset asserted mid-burst or with a read in flight SHALL cancel the pending rvalid and clear burst_cnt on that edge.

Structure
REQ-034 A shared package SHALL hold:
- the state enum (IDLE, CORE, DBG);
- the owner enum (OWN_CORE, OWN_DBG);
- the default BURST_MAX constant.
REQ-035 The round-robin/burst FSM SHALL be one sub-module, arb_fsm; the datapath muxing and read-return registers SHALL stay in the top module.

Verification
REQ-036 Core-only load: core_req=1, we=0, addr=0x10, mem_rdata=0xAB -> core_gnt same cycle, mem_read=1, core_rvalid=1 with core_rdata=0xAB next cycle.
REQ-037 Simultaneous requests after reset, both held high -> grants alternate core, dbg, core, dbg; core_stall=1 exactly on dbg-granted cycles.
REQ-038 Locked burst: dbg_lock=1, BURST_MAX=4, both requesting continuously -> 4 consecutive dbg_gnt, then core_gnt, then round-robin.
REQ-039 Debug store: dbg_req=1, we=1, addr=0x20, wdata=0x55 -> mem_write=1, mem_addr=0x20, mem_wdata=0x55, no rvalid.
REQ-040 Reset mid-operation: reset in the cycle after a granted read -> no rvalid, all outputs 0, first tie after reset goes to core.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_e : arbiter FSM state, named after who was granted last cycle
//   owner_e : which requester port was granted most recently
//   BURST_MAX_DEF : default cap on consecutive locked debug grants
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        DBG  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/data_mem_arbiter_arb_fsm.sv
// Round-robin / debug-burst grant FSM.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   core_req, dbg_req    : requests from the two ports
//   dbg_lock             : debug asks to keep ownership for a burst
//   core_gnt, dbg_gnt    : one-hot-or-zero grants, combinational this cycle
module arb_fsm
    import data_mem_arbiter_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req,
    input  logic dbg_req,
    input  logic dbg_lock,
    output logic core_gnt,
    output logic dbg_gnt
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    state_e           state_q, state_d;
    owner_e           last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             lock_win;

    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        // Debug keeps the port only while it was the owner last cycle and
        // has not yet used up its burst allowance.
        lock_win = (state_q == DBG) && dbg_lock && (burst_cnt_q < BURST_LIM);
        if (!reset) begin
            if (core_req && dbg_req) begin
                if (lock_win || last_owner_q == OWN_CORE) dbg_gnt  = 1'b1;
                else                                      core_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end

        state_d      = core_gnt ? CORE : (dbg_gnt ? DBG : IDLE);
        last_owner_d = core_gnt ? OWN_CORE : (dbg_gnt ? OWN_DBG : last_owner_q);

        // Burst count only tracks debug grants that actually starve the core;
        // a debug grant with the core idle leaves it unchanged.
        burst_cnt_d = '0;
        if (dbg_gnt) begin
            if (!core_req)                   burst_cnt_d = burst_cnt_q;
            else if (burst_cnt_q == BURST_LIM) burst_cnt_d = burst_cnt_q;
            else                             burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_DBG;  // core wins the first tie
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port (core + debug/loader) arbiter in front of a single data memory.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   core_req/we/addr/wdata             : core load/store request
//   core_gnt/rvalid/rdata, core_stall  : core grant, load return, PC freeze
//   dbg_req/we/lock/addr/wdata         : debug request and burst lock
//   dbg_gnt/rvalid/rdata               : debug grant and load return
//   mem_read/write/addr/wdata          : memory strobes and address/data
//   mem_rdata                          : memory read data (combinational)
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              core_rvalid_q, core_rvalid_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    arb_fsm #(.BURST_MAX(BURST_MAX)) u_arb_fsm (
        .clk      (clk),
        .reset    (reset),
        .core_req (core_req),
        .dbg_req  (dbg_req),
        .dbg_lock (dbg_lock),
        .core_gnt (core_gnt),
        .dbg_gnt  (dbg_gnt)
    );

    always_comb begin
        // Core drives the memory bus by default, including when idle.
        mem_addr  = dbg_gnt ? dbg_addr  : core_addr;
        mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;
        mem_read  = (core_gnt && !core_we) || (dbg_gnt && !dbg_we);
        mem_write = (core_gnt &&  core_we) || (dbg_gnt &&  dbg_we);

        core_rvalid_d = core_gnt && !core_we;
        dbg_rvalid_d  = dbg_gnt  && !dbg_we;
        core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d  ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            core_rdata_q  <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    // Masking with reset kills a return that was launched the edge before
    // reset rose, so nothing leaks out during the reset cycle itself.
    assign core_rvalid = core_rvalid_q && !reset;
    assign dbg_rvalid  = dbg_rvalid_q  && !reset;
    assign core_rdata  = reset ? '0 : core_rdata_q;
    assign dbg_rdata   = reset ? '0 : dbg_rdata_q;
    assign core_stall  = core_req && !core_gnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata;
    logic          core_gnt, core_rvalid, core_stall, dbg_gnt, dbg_rvalid;
    logic [DW-1:0] core_rdata, dbg_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory: fixed content function of the address.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 64'h10) return 64'hAB;
        return {a[31:0] ^ 32'h5a5a_1234, a[31:0] * 32'd3 + 32'd7};
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // prev: who got the port last cycle (0 none, 1 core, 2 dbg)
    // last: most recent owner ever granted (1 core, 2 dbg)
    int            m_prev = 0;
    int            m_last = 2;
    int            m_burst = 0;
    bit            m_crv = 0, m_drv = 0;
    logic [DW-1:0] m_crd = '0, m_drd = '0;

    always @(negedge clk) begin
        bit            gc, gd, lk;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        gc = 0; gd = 0;
        if (!reset) begin
            if (core_req && dbg_req) begin
                lk = (m_prev == 2) && dbg_lock && (m_burst < BM);
                if (lk || m_last == 1) gd = 1; else gc = 1;
            end else begin
                gc = core_req; gd = dbg_req;
            end
        end
        ea = gd ? dbg_addr : core_addr;
        ew = gd ? dbg_wdata : core_wdata;
        chk("core_gnt", 64'(core_gnt), 64'(gc));
        chk("dbg_gnt", 64'(dbg_gnt), 64'(gd));
        chk("core_stall", 64'(core_stall), 64'(core_req && !gc));
        chk("mem_read", 64'(mem_read), 64'((gc && !core_we) || (gd && !dbg_we)));
        chk("mem_write", 64'(mem_write), 64'((gc && core_we) || (gd && dbg_we)));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("core_rvalid", 64'(core_rvalid), 64'(m_crv && !reset));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(m_drv && !reset));
        chk("core_rdata", core_rdata, reset ? 64'h0 : m_crd);
        chk("dbg_rdata", dbg_rdata, reset ? 64'h0 : m_drd);
        // advance model to the state after the coming rising edge
        if (reset) begin
            m_prev = 0; m_last = 2; m_burst = 0;
            m_crv = 0; m_drv = 0; m_crd = '0; m_drd = '0;
        end else begin
            m_crv = gc && !core_we;
            m_drv = gd && !dbg_we;
            if (m_crv) m_crd = mem_fn(ea);
            if (m_drv) m_drd = mem_fn(ea);
            m_prev = gc ? 1 : (gd ? 2 : 0);
            if (gc) m_last = 1;
            if (gd) m_last = 2;
            if (!gd) m_burst = 0;
            else if (core_req && m_burst < BM) m_burst = m_burst + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit cr, input bit cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input bit dr, input bit dw, input bit dl,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        @(posedge clk); #1;
        reset = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        drive(r, 0, 0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 64'h0);
    endtask

    task automatic both(input bit lk);
        drive(0, 1, 0, 64'h100, 64'h0, 1, 0, lk, 64'h200, 64'h0);
    endtask

    initial begin
        logic [6:0] exp_c;
        reset = 1; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
        idle(1);
        drive(1, 1, 0, 64'h10, 64'h0, 1, 0, 0, 64'h20, 64'h0);
        chk("rst_gnt", {62'h0, core_gnt, dbg_gnt}, 64'h0);
        chk("rst_mem", {62'h0, mem_read, mem_write}, 64'h0);
        chk("rst_rvalid", {62'h0, core_rvalid, dbg_rvalid}, 64'h0);
        chk("rst_rdata", core_rdata | dbg_rdata, 64'h0);

        // core-only load
        drive(0, 1, 0, 64'h10, 64'h0, 0, 0, 0, 64'h0, 64'h0);
        chk("ld_gnt", 64'(core_gnt), 64'h1);
        chk("ld_mem_read", 64'(mem_read), 64'h1);
        chk("ld_addr", mem_addr, 64'h10);
        idle(0);
        chk("ld_rvalid", 64'(core_rvalid), 64'h1);
        chk("ld_rdata", core_rdata, 64'hAB);
        idle(0);
        chk("ld_rvalid_off", 64'(core_rvalid), 64'h0);
        chk("ld_rdata_hold", core_rdata, 64'hAB);

        // simultaneous requests after reset: c,d,c,d
        idle(1);
        for (int i = 0; i < 4; i++) begin
            both(0);
            chk("rr_core_gnt", 64'(core_gnt), 64'(i % 2 == 0));
            chk("rr_dbg_gnt", 64'(dbg_gnt), 64'(i % 2 == 1));
            chk("rr_stall", 64'(core_stall), 64'(i % 2 == 1));
        end

        // locked burst: c, d x4, c, then round-robin d
        idle(1);
        exp_c = 7'b0100001;  // bit i = core granted in cycle i
        for (int i = 0; i < 7; i++) begin
            both(1);
            chk("burst_core_gnt", 64'(core_gnt), 64'(exp_c[i]));
            chk("burst_dbg_gnt", 64'(dbg_gnt), 64'(!exp_c[i]));
        end

        // debug store
        idle(1);
        drive(0, 0, 0, 64'h0, 64'h0, 1, 1, 0, 64'h20, 64'h55);
        chk("st_write", {62'h0, mem_write, mem_read}, 64'h2);
        chk("st_addr", mem_addr, 64'h20);
        chk("st_wdata", mem_wdata, 64'h55);
        idle(0);
        chk("st_no_rvalid", {62'h0, core_rvalid, dbg_rvalid}, 64'h0);

        // reset with a read in flight
        drive(0, 1, 0, 64'h30, 64'h0, 0, 0, 0, 64'h0, 64'h0);
        chk("rip_gnt", 64'(core_gnt), 64'h1);
        drive(1, 1, 0, 64'h30, 64'h0, 1, 0, 0, 64'h40, 64'h0);
        chk("rip_rvalid", {62'h0, core_rvalid, dbg_rvalid}, 64'h0);
        chk("rip_gnt_off", {60'h0, core_gnt, dbg_gnt, mem_read, mem_write}, 64'h0);
        both(0);
        chk("rip_first_tie", {62'h0, core_gnt, dbg_gnt}, 64'h2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  64'($urandom_range(0, 255)), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0,
                  64'($urandom_range(0, 255)), {$urandom, $urandom});
        end
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
